ssd_scan_mux: RTL and testbench

//  Downstream stage of the 4x4 multiplier display path. Takes the three active-low
//  7-segment codes (hundreds/tens/units), double-buffers them, and time-multiplexes

---
 rtl/ssd_scan_mux.sv | 195 +++++++++++++++++++
 tb/tb_ssd_scan_mux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: three-digit multiplexed 7-segment driver with double buffering.
// Time-multiplexes hundreds/tens/units codes onto one active-low segment bus
// with active-low digit enables and blanking slots between digits.
// Optional feature: define SSD_LZ_BLANK_EN to suppress leading zeros.
module ssd_scan_mux #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dig_1,
    input  logic [6:0] dig_2,
    input  logic [6:0] dig_3,
    input  logic       upd,
    output logic [6:0] seg,
    output logic [2:0] an
,
    output logic       frame
);

    localparam int MAX_DUR = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    localparam logic [2:0] AN_OFF = 3'b111;
    localparam logic [2:0] AN_H   = 3'b110;
    localparam logic [2:0] AN_T   = 3'b101;
    localparam logic [2:0] AN_U   = 3'b011;

    typedef enum logic [2:0] {
        BLANK_H,
        SHOW_H,
        BLANK_T,
        SHOW_T,
        BLANK_U,
        SHOW_U
    } scan_state_t;

    scan_state_t state;
    scan_state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [6:0] stage_h;
    logic [6:0] stage_t;
    logic [6:0] stage_u;
    logic [6:0] shadow_h;
    logic [6:0] shadow_t;
    logic [6:0] shadow_u;
    logic       pending;

    logic       slot_last;
    logic       commit;
    logic [6:0] seg_nxt;
    logic [2:0] an_nxt;
    logic       frame_nxt;

    logic       hide_h;
    logic       hide_t;

`ifdef SSD_LZ_BLANK_EN
    // Leading-zero suppression: hundreds hides on "0", tens only if hundreds is also hidden.
    always_comb begin
        hide_h = (shadow_h == SEG_ZERO);
        hide_t = hide_h && (shadow_t == SEG_ZERO);
    end
`else
    // All digits are always shown exactly as stored.
    always_comb begin
        hide_h = 1'b0;
        hide_t = 1'b0;
    end
`endif

    // Slot sequencing: count out the current slot, then step to the next digit/blank slot.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_ONE;
        slot_last = 1'b0;
        case (state)
            SHOW_H, SHOW_T, SHOW_U: slot_last = (cnt == SHOW_LAST);
            default:                slot_last = (cnt == BLANK_LAST);
        endcase
        if (slot_last) begin
            cnt_nxt = '0;
            case (state)
                BLANK_H: state_nxt = SHOW_H;
                SHOW_H:  state_nxt = BLANK_T;
                BLANK_T: state_nxt = SHOW_T;
                SHOW_T:  state_nxt = BLANK_U;
                BLANK_U: state_nxt = SHOW_U;
                SHOW_U:  state_nxt = BLANK_H;
                default: state_nxt = BLANK_H;
            endcase
        end
        commit = (state == SHOW_U) && slot_last;
    end

    // Output decode for the slot being entered, so outputs move on the same edge as state.
    always_comb begin
        an_nxt    = AN_OFF;
        seg_nxt   = SEG_BLANK;
        frame_nxt = commit;
        case (state_nxt)
            SHOW_H: begin
                if (!hide_h) begin
                    an_nxt  = AN_H;
                    seg_nxt = shadow_h;
                end
            end
            SHOW_T: begin
                if (!hide_t) begin
                    an_nxt  = AN_T;
                    seg_nxt = shadow_t;
                end
            end
            SHOW_U: begin
                an_nxt  = AN_U;
                seg_nxt = shadow_u;
            end
            default: begin
                an_nxt  = AN_OFF;
                seg_nxt = SEG_BLANK;
            end
        endcase
    end

    // Scan state, slot counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK_H;
            cnt   <= '0;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
            frame <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            seg   <= seg_nxt;
            an    <= an_nxt;
            frame <= frame_nxt;
        end
    end

    // Staging capture: the most recent upd strobe always overwrites the staged codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_h <= SEG_BLANK;
            stage_t <= SEG_BLANK;
            stage_u <= SEG_BLANK;
        end else if (upd) begin
            stage_h <= dig_1;
            stage_t <= dig_2;
            stage_u <= dig_3;
        end
    end

    // Shadow update only at the frame wrap; a same-cycle upd bypasses staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_h <= SEG_BLANK;
            shadow_t <= SEG_BLANK;
            shadow_u <= SEG_BLANK;
        end else if (commit) begin
            if (upd) begin
                shadow_h <= dig_1;
                shadow_t <= dig_2;
                shadow_u <= dig_3;
            end else if (pending) begin
                shadow_h <= stage_h;
                shadow_t <= stage_t;
                shadow_u <= stage_u;
            end
        end
    end

    // Pending flag: raised by upd, consumed by the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b0;
        end else if (upd) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Testbench for ssd_scan_mux with SCAN_DIV=4, BLANK_CYC=1 (15-cycle frame).
// Expected per-cycle display outputs are queued frame by frame and popped each cycle.
module tb_ssd_scan_mux;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;

    logic       clk;
    logic       rst;
    logic [6:0] dig_1;
    logic [6:0] dig_2;
    logic [6:0] dig_3;
    logic       upd;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t sb[$];
    int   n_compared;
    int   n_mismatch;

    ssd_scan_mux #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dig_1(dig_1),
        .dig_2(dig_2),
        .dig_3(dig_3),
        .upd  (upd),
        .seg  (seg),
        .an   (an),
        .frame(frame)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queue the expected outputs for frame positions first_p..last_p of a frame showing h/t/u.
    task automatic push_frame(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u,
                              input logic wrap, input int first_p, input int last_p);
        exp_t e;
        logic lz_h;
        logic lz_t;
        lz_h = 1'b0;
        lz_t = 1'b0;
`ifdef SSD_LZ_BLANK_EN
        lz_h = (h == 7'h40);
        lz_t = lz_h && (t == 7'h40);
`endif
        for (int p = first_p; p <= last_p; p++) begin
            e.frame = wrap && (p == 0);
            if (p >= 1 && p <= 4 && !lz_h) begin
                e.an  = 3'b110;
                e.seg = h;
            end else if (p >= 6 && p <= 9 && !lz_t) begin
                e.an  = 3'b101;
                e.seg = t;
            end else if (p >= 11 && p <= 14) begin
                e.an  = 3'b011;
                e.seg = u;
            end else begin
                e.an  = 3'b111;
                e.seg = 7'h7F;
            end
            sb.push_back(e);
        end
    endtask

    task automatic load_digits(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        dig_1 = h;
        dig_2 = t;
        dig_3 = u;
        upd   = 1'b1;
    endtask

    task automatic release_upd();
        upd   = 1'b0;
        dig_1 = 7'($urandom);
        dig_2 = 7'($urandom);
        dig_3 = 7'($urandom);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_compared++;
            if ({an, seg, frame} !== {3'b111, 7'h7F, 1'b0}) begin
                n_mismatch++;
                $display("[TB] FAIL reset c=%0d: got an=%b seg=%h frame=%b, want an=111 seg=7f frame=0",
                         c, an, seg, frame);
            end
        end
        rst = 1'b0;
        push_frame(7'h7F, 7'h7F, 7'h7F, 1'b0, 1, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL post_reset c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
        end
    endtask

    task automatic test_product();
        exp_t e;
        push_frame(7'h7F, 7'h7F, 7'h7F, 1'b1, 0, 14);
        push_frame(7'h24, 7'h24, 7'h12, 1'b1, 0, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL product c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
            if (c == 7) load_digits(7'h24, 7'h24, 7'h12);
            if (c == 8) release_upd();
        end
    endtask

    task automatic test_two_upd();
        exp_t e;
        push_frame(7'h24, 7'h24, 7'h12, 1'b1, 0, 14);
        push_frame(7'h00, 7'h10, 7'h40, 1'b1, 0, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL two_upd c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
            if (c == 2) load_digits(7'h79, 7'h79, 7'h79);
            if (c == 3) release_upd();
            if (c == 8) load_digits(7'h00, 7'h10, 7'h40);
            if (c == 9) release_upd();
        end
    endtask

    task automatic test_commit_edge();
        exp_t e;
        push_frame(7'h00, 7'h10, 7'h40, 1'b1, 0, 14);
        push_frame(7'h12, 7'h24, 7'h79, 1'b1, 0, 14);
        push_frame(7'h12, 7'h24, 7'h79, 1'b1, 0, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL commit_edge c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
            if (c == 14) load_digits(7'h12, 7'h24, 7'h79);
            if (c == 15) release_upd();
        end
    endtask

    task automatic test_lz();
        exp_t e;
        push_frame(7'h12, 7'h24, 7'h79, 1'b1, 0, 14);
        push_frame(7'h40, 7'h40, 7'h78, 1'b1, 0, 14);
        push_frame(7'h40, 7'h40, 7'h40, 1'b1, 0, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL lz c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
            if (c == 2)  load_digits(7'h40, 7'h40, 7'h78);
            if (c == 3)  release_upd();
            if (c == 17) load_digits(7'h40, 7'h40, 7'h40);
            if (c == 18) release_upd();
        end
    endtask

    task automatic test_back_to_back_reset();
        exp_t e;
        exp_t r;
        push_frame(7'h40, 7'h40, 7'h40, 1'b1, 0, 7);
        r.an    = 3'b111;
        r.seg   = 7'h7F;
        r.frame = 1'b0;
        sb.push_back(r);
        push_frame(7'h7F, 7'h7F, 7'h7F, 1'b0, 1, 14);
        push_frame(7'h7F, 7'h7F, 7'h7F, 1'b1, 0, 14);
        for (int c = 0; sb.size() > 0; c++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_compared++;
            if ({an, seg, frame} !== {e.an, e.seg, e.frame}) begin
                n_mismatch++;
                $display("[TB] FAIL mid_reset c=%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         c, an, seg, frame, e.an, e.seg, e.frame);
            end
            if (c == 2) load_digits(7'h12, 7'h12, 7'h12);
            if (c == 3) release_upd();
            if (c == 7) rst = 1'b1;
            if (c == 8) rst = 1'b0;
        end
    endtask

    // Test sequence: each task leaves the DUT at the last cycle of a frame.
    initial begin
        n_compared = 0;
        n_mismatch = 0;
        rst   = 1'b1;
        upd   = 1'b0;
        dig_1 = 7'h7F;
        dig_2 = 7'h7F;
        dig_3 = 7'h7F;
        test_reset();
        test_product();
        test_two_upd();
        test_commit_edge();
        test_lz();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
